// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the SPI-attached RAM controller.
//   CTRL_WIDTH   : width of the command field at the top of each SPI frame
//   cmd_t        : command encoding carried in rx_data[FRAME_WIDTH+1:FRAME_WIDTH]
//   ctrl_state_t : controller FSM states
package spi_pkg;

  localparam int unsigned CTRL_WIDTH = 2;

  typedef enum logic [CTRL_WIDTH-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WR_MEM  = 2'b01,
    RD_MEM  = 2'b10,
    TX_HOLD = 2'b11
  } ctrl_state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port synchronous RAM, FRAME_WIDTH x 2**ADDR_WIDTH.
// Write and read share one address; the read is registered (1-cycle latency)
// and the read register only updates when re_i is high. No reset on contents.
// Ports:
//   clk     : clock
//   we_i    : write enable, mem[addr_i] <= wdata_i
//   re_i    : read enable,  rdata_o <= mem[addr_i] next cycle
//   addr_i  : shared address
//   wdata_i : write data
//   rdata_o : registered read data
module spi_ram_mem #(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [FRAME_WIDTH-1:0] wdata_i,
  output logic [FRAME_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [FRAME_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [FRAME_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder that lets an SPI slave read and write a small
// on-chip RAM. Each received frame carries a 2-bit command and a payload byte.
// Optional feature: define SPI_RAM_CTRL_AUTOINC_EN to post-increment wr_addr
// after every memory write and rd_addr after every memory read (wrapping).
// Ports:
//   clk      : sole clock, rising edge
//   rst_n    : synchronous active-low reset
//   rx_valid : frame-received level from the SPI slave
//   rx_data  : {command, payload} frame
//   tx_valid : read byte available to the slave (high only in TX_HOLD)
//   tx_data  : read byte for MISO; holds its last value outside TX_HOLD
//   busy     : controller not idle
//   cmd_err  : one-cycle pulse on an accepted command that cannot be executed
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx_valid,
  input  logic [FRAME_WIDTH+CTRL_WIDTH-1:0] rx_data,
  output logic                              tx_valid,
  output logic [FRAME_WIDTH-1:0]            tx_data,
  output logic                              busy,
  output logic                              cmd_err
);

  ctrl_state_t            state_q, state_d;
  logic                   rx_valid_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                   rd_seen_q, rd_seen_d;
  logic [FRAME_WIDTH-1:0] payload_q, payload_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [FRAME_WIDTH-1:0] tx_data_q;

  logic                   accept;
  cmd_t                   cmd;
  logic [FRAME_WIDTH-1:0] payload;

  logic                   mem_we;
  logic                   mem_re;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [FRAME_WIDTH-1:0] mem_rdata;

  assign accept  = rx_valid & ~rx_valid_q;
  assign cmd     = cmd_t'(rx_data[FRAME_WIDTH+CTRL_WIDTH-1:FRAME_WIDTH]);
  assign payload = rx_data[FRAME_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_seen_d = rd_seen_q;
    payload_d = payload_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = wr_addr_q;

    // Any new frame while a transaction is in flight is dropped and flagged.
    if (accept && (state_q != IDLE)) begin
      cmd_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd)
            CMD_WR_ADDR: wr_addr_d = payload[ADDR_WIDTH-1:0];
            CMD_RD_ADDR: begin
              rd_addr_d = payload[ADDR_WIDTH-1:0];
              rd_seen_d = 1'b1;
            end
            CMD_WR_DATA: begin
              payload_d = payload;
              state_d   = WR_MEM;
            end
            CMD_RD_DATA: begin
              // Read still proceeds (from the reset address) but is flagged.
              if (!rd_seen_q) begin
                cmd_err_d = 1'b1;
              end
              state_d = RD_MEM;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      WR_MEM: begin
        // Gated by rst_n so a reset landing on this edge suppresses the write.
        mem_we   = rst_n;
        mem_addr = wr_addr_q;
        state_d  = IDLE;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
`endif
      end
      RD_MEM: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr_q;
        state_d  = TX_HOLD;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
`endif
      end
      TX_HOLD: begin
        if (!rx_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_seen_q  <= 1'b0;
      payload_q  <= '0;
      cmd_err_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_seen_q  <= rd_seen_d;
      payload_q  <= payload_d;
      cmd_err_q  <= cmd_err_d;
      if (state_q == TX_HOLD) begin
        tx_data_q <= mem_rdata;
      end
    end
  end

  spi_ram_mem #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (payload_q),
    .rdata_o (mem_rdata)
  );

  // The RAM read register lands exactly on TX_HOLD entry and is not touched
  // again until the next RD_MEM, so it is driven straight out during TX_HOLD;
  // tx_data_q captures it there to hold the byte afterwards and to give a
  // resettable value outside TX_HOLD.
  assign tx_valid = (state_q == TX_HOLD);
  assign tx_data  = tx_valid ? mem_rdata : tx_data_q;
  assign busy     = (state_q != IDLE);
  assign cmd_err  = cmd_err_q;

endmodule
